edac_2x4bit_encoder: RTL and testbench

Write-side companion of the 2x4-bit EDAC read path. It takes an 8-bit data byte and encodes each nibble into a 16-bit linear codeword. The two codewords are packed into one 32-bit protected word. Encoded words are buffered in a small FIFO and drained to memory or the bus with a valid/ready handshake, so that the EDAC decoder can later check and correct them on READ.

---
 rtl/edac_2x4bit_encoder.sv | 78 +++++++
 tb/tb_edac_2x4bit_encoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/edac_2x4bit_encoder.sv
// edac_2x4bit_encoder: packs two nibble codewords per byte and buffers them in a valid/ready FIFO.
// Optional EDAC_ERR_INJ_EN adds ERR_INJ/ERR_MASK error injection and the INJ_CNT counter.
module edac_2x4bit_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       DIN,
    output logic             RDY,
    output logic [31:0]      DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
`ifdef EDAC_ERR_INJ_EN
    input  logic             ERR_INJ,
    input  logic [31:0]      ERR_MASK,
    output logic [CNT_W-1:0] INJ_CNT,
`endif
    output logic [CNT_W-1:0] WORD_CNT
);
    localparam int PW = $clog2(DEPTH);

    function automatic logic [15:0] enc(input logic [3:0] d);
        enc = ({16{d[0]}} & 16'h07CA) ^ ({16{d[1]}} & 16'h19CC) ^
              ({16{d[2]}} & 16'h2A54) ^ ({16{d[3]}} & 16'h4B80);
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [PW:0]   count, count_n;
    logic [31:0]   wdata, head_n;
    logic          push, pop;

    assign push = en & RDY;
    assign pop  = DOUT_VALID & DOUT_READY;
`ifdef EDAC_ERR_INJ_EN
    assign wdata = {enc(DIN[7:4]), enc(DIN[3:0])} ^ (ERR_INJ ? ERR_MASK : 32'h0);
`else
    assign wdata = {enc(DIN[7:4]), enc(DIN[3:0])};
`endif

    always_comb begin
        rd_n    = rd_ptr + PW'(pop);
        count_n = count + (PW+1)'(push) - (PW+1)'(pop);
        // the word written this edge becomes the head only when it is the sole entry left
        head_n  = (push && wr_ptr == rd_n) ? wdata : mem[rd_n];
    end

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= wdata;

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            DOUT       <= 32'h0;
            DOUT_VALID <= 1'b0;
            RDY        <= 1'b0;
            WORD_CNT   <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_n;
            count      <= count_n;
            DOUT       <= (count_n != 0) ? head_n : 32'h0;
            DOUT_VALID <= count_n != 0;
            RDY        <= count_n != (PW+1)'(DEPTH);
            WORD_CNT   <= WORD_CNT + CNT_W'(push);
        end
    end

`ifdef EDAC_ERR_INJ_EN
    always_ff @(posedge CLK)
        if (reset) INJ_CNT <= '0;
        else       INJ_CNT <= INJ_CNT + CNT_W'(push & ERR_INJ);
`endif
endmodule

// File: tb/tb_edac_2x4bit_encoder.sv
// tb_edac_2x4bit_encoder: directed checks of encoding, FIFO flow control and reset flush.
module tb_edac_2x4bit_encoder;
    logic        CLK = 0, reset = 1, en = 0, DOUT_READY = 0;
    logic [7:0]  DIN = 0;
    logic        RDY, DOUT_VALID;
    logic [31:0] DOUT;
    logic [15:0] WORD_CNT;
    int          tests = 0, fails = 0;
`ifdef EDAC_ERR_INJ_EN
    logic        ERR_INJ = 0;
    logic [31:0] ERR_MASK = 0;
    logic [15:0] INJ_CNT;
`endif

    edac_2x4bit_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .en(en), .DIN(DIN), .RDY(RDY),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
`ifdef EDAC_ERR_INJ_EN
        .ERR_INJ(ERR_INJ), .ERR_MASK(ERR_MASK), .INJ_CNT(INJ_CNT),
`endif
        .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] model_enc(input logic [3:0] d);
        logic [15:0] rows [4];
        logic [15:0] r;
        rows[0] = 16'h07CA; rows[1] = 16'h19CC; rows[2] = 16'h2A54; rows[3] = 16'h4B80;
        r = 16'h0;
        for (int b = 0; b < 4; b++)
            if (d[b]) r = r ^ rows[b];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_dout", DOUT, 32'h0);
        chk("rst_valid", 32'(DOUT_VALID), 32'h0);
        chk("rst_rdy", 32'(RDY), 32'h0);
        chk("rst_cnt", 32'(WORD_CNT), 32'h0);

        reset = 0;
        tick();
        chk("rel_rdy", 32'(RDY), 32'h1);
        chk("rel_valid", 32'(DOUT_VALID), 32'h0);

        en = 1; DIN = 8'h21; DOUT_READY = 1;
        tick();
        chk("w21_dout", DOUT, 32'h19CC07CA);
        chk("w21_valid", 32'(DOUT_VALID), 32'h1);
        chk("w21_cnt", 32'(WORD_CNT), 32'h1);
        en = 0;
        tick();
        chk("w21_drain_valid", 32'(DOUT_VALID), 32'h0);
        chk("w21_drain_dout", DOUT, 32'h0);

        en = 1;
        for (int i = 0; i < 256; i++) begin
            DIN = 8'(i);
            tick();
            chk("sweep", DOUT, {model_enc(4'(i >> 4)), model_enc(4'(i))});
            chk("sweep_valid", 32'(DOUT_VALID), 32'h1);
        end
        chk("sweep_ff", DOUT, 32'h7FD27FD2);
        chk("sweep_cnt", 32'(WORD_CNT), 32'd257);
        en = 0;
        tick();
        chk("sweep_drain", 32'(DOUT_VALID), 32'h0);

        DOUT_READY = 0; en = 1; DIN = 8'h12;
        tick();
        chk("full_w1", DOUT, 32'h07CA19CC);
        chk("full_rdy1", 32'(RDY), 32'h1);
        DIN = 8'h34;
        tick();
        chk("full_rdy2", 32'(RDY), 32'h0);
        chk("full_hold", DOUT, 32'h07CA19CC);
        DIN = 8'h56;
        tick();
        chk("full_drop_hold", DOUT, 32'h07CA19CC);
        chk("full_drop_cnt", 32'(WORD_CNT), 32'd259);
        chk("full_drop_rdy", 32'(RDY), 32'h0);

        DIN = 8'h78; DOUT_READY = 1;
        tick();
        chk("popfull_dout", DOUT, 32'h1E062A54);
        chk("popfull_rdy", 32'(RDY), 32'h1);
        chk("popfull_cnt", 32'(WORD_CNT), 32'd259);
        en = 0;
        tick();
        chk("popfull_empty", 32'(DOUT_VALID), 32'h0);

        DOUT_READY = 0; en = 1; DIN = 8'h9A;
        tick();
        DIN = 8'hBC;
        tick();
        chk("flush_pre_cnt", 32'(WORD_CNT), 32'd261);
        chk("flush_pre_valid", 32'(DOUT_VALID), 32'h1);
        reset = 1; en = 0;
        tick();
        chk("flush_valid", 32'(DOUT_VALID), 32'h0);
        chk("flush_dout", DOUT, 32'h0);
        chk("flush_cnt", 32'(WORD_CNT), 32'h0);
        chk("flush_rdy", 32'(RDY), 32'h0);
        reset = 0; DOUT_READY = 1;
        tick();
        chk("flush_post_rdy", 32'(RDY), 32'h1);
        chk("flush_post_valid", 32'(DOUT_VALID), 32'h0);
        tick();
        chk("flush_post_valid2", 32'(DOUT_VALID), 32'h0);
        chk("flush_post_dout", DOUT, 32'h0);

`ifdef EDAC_ERR_INJ_EN
        chk("inj_rst", 32'(INJ_CNT), 32'h0);
        en = 1; DIN = 8'h00; ERR_INJ = 1; ERR_MASK = 32'h00000800;
        tick();
        chk("inj_dout", DOUT, 32'h00000800);
        chk("inj_cnt", 32'(INJ_CNT), 32'h1);
        ERR_INJ = 0; DIN = 8'h21;
        tick();
        chk("inj_clean", DOUT, 32'h19CC07CA);
        chk("inj_cnt_hold", 32'(INJ_CNT), 32'h1);
        en = 0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
